// File: rtl/ld_st_shift_reg.sv
// ld_st_shift_reg: 4-bit universal register.
// Modes are hold, parallel load, shift left and shift right.
// clr is an asynchronous clear to 0000 and has the highest priority.
// set is a synchronous, active-low preset to 1111 and overrides the mode select.
// out is driven directly from the state flops.
module ld_st_shift_reg (
    input  logic       clk,
    input  logic       clr,
    input  logic       set,
    input  logic [1:0] cntrl,
    input  logic       inLS,
    input  logic       inRS,
    input  logic [3:0] in,
    output logic [3:0] out
);

    // Mode encoding of cntrl
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

    localparam logic [3:0] CLEAR_VAL  = 4'b0000;
    localparam logic [3:0] PRESET_VAL = 4'b1111;

    mode_e      mode;
    logic [3:0] out_d;
    logic [3:0] out_q;

    assign mode = mode_e'(cntrl);

    // Next-state select: preset beats every mode; shifts are logical, with no wrap-around
    always_comb begin
        out_d = out_q;
        if (!set) begin
            out_d = PRESET_VAL;
        end else begin
            case (mode)
                MODE_HOLD: out_d = out_q;
                MODE_LOAD: out_d = in;
                MODE_SHL:  out_d = {out_q[2:0], inLS};
                MODE_SHR:  out_d = {inRS, out_q[3:1]};
                default:   out_d = out_q;
            endcase
        end
    end

    // State register; clr clears it at once, without waiting for a clock edge
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_q <= CLEAR_VAL;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_ld_st_shift_reg.sv
// Self-checking bench for ld_st_shift_reg.
// A behavioural model computes the next register value from the sampled inputs.
// A compare process checks out against that model 1 ns after every posedge.
// Directed steps also pin both the DUT and the model to hand-computed literals.
module tb_ld_st_shift_reg;

  logic       clk;
  logic       clr;
  logic       set;
  logic [1:0] cntrl;
  logic       inLS;
  logic       inRS;
  logic [3:0] d_in;
  logic [3:0] out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_out = 4'b0000;

  ld_st_shift_reg dut (
    .clk   (clk),
    .clr   (clr),
    .set   (set),
    .cntrl (cntrl),
    .inLS  (inLS),
    .inRS  (inRS),
    .in    (d_in),
    .out   (out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  initial begin
    logic [3:0] nxt;
    forever begin
      @(posedge clk);
      if (clr)
        nxt = 4'b0000;
      else if (!set)
        nxt = 4'b1111;
      else if (cntrl == 2'd0)
        nxt = exp_out;
      else if (cntrl == 2'd1)
        nxt = d_in;
      else if (cntrl == 2'd2)
        nxt = 4'((exp_out * 2 + {3'b000, inLS}) % 16);
      else
        nxt = 4'(exp_out / 2 + (inRS ? 8 : 0));
      exp_out = nxt;
      #1;
      check("cycle", out, exp_out);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [1:0] c, input logic ls, input logic rs, input logic [3:0] d);
    @(negedge clk);
    set   = s;
    cntrl = c;
    inLS  = ls;
    inRS  = rs;
    d_in  = d;
  endtask

  // Wait for the edge, then pin the DUT and the model to a literal
  task automatic step(input string name, input logic [3:0] lit);
    @(posedge clk);
    #2;
    check({name, "_dut"}, out, lit);
    check({name, "_model"}, exp_out, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] bits;
    logic [3:0] want;
    clr = 1'b1; set = 1'b1; cntrl = 2'b00; inLS = 1'b0; inRS = 1'b0; d_in = 4'b0000;
    step("reset", 4'b0000);
    drive(1, 2'b00, 0, 0, 4'b0000);
    clr = 1'b0;
    step("after_reset_hold", 4'b0000);

    // Asynchronous clear from 1010, checked before the next posedge
    drive(1, 2'b01, 0, 0, 4'b1010);
    step("load_1010", 4'b1010);
    @(negedge clk);
    #1 clr = 1'b1;
    #1 check("async_clr", out, 4'b0000);
    set = 1'b0; cntrl = 2'b01; d_in = 4'b1111;
    for (int k = 0; k < 3; k++) step("clr_over_set", 4'b0000);
    drive(1, 2'b00, 0, 0, 4'b0000);
    clr = 1'b0;
    step("clr_release_hold", 4'b0000);

    // Preset priority over shift and load
    drive(0, 2'b11, 0, 0, 4'b0000);
    step("preset_shr", 4'b1111);
    drive(1, 2'b01, 0, 0, 4'b0110);
    step("load_0110_a", 4'b0110);
    drive(0, 2'b01, 0, 0, 4'b0000);
    step("preset_load", 4'b1111);

    // Load then hold while in changes
    drive(1, 2'b01, 0, 0, 4'b0110);
    step("load_0110_b", 4'b0110);
    for (int k = 0; k < 5; k++) begin
      drive(1, 2'b00, 1'($urandom), 1'($urandom), 4'($urandom));
      step("hold", 4'b0110);
    end

    // Shift left
    drive(1, 2'b10, 1, 0, 4'b0000);
    step("shl_in1", 4'b1101);
    drive(1, 2'b10, 0, 0, 4'b0000);
    step("shl_in0", 4'b1010);
    drive(0, 2'b00, 0, 0, 4'b0000);
    step("preset_ff", 4'b1111);
    drive(1, 2'b10, 0, 0, 4'b0000);
    step("shl4_1", 4'b1110);
    step("shl4_2", 4'b1100);
    step("shl4_3", 4'b1000);
    step("shl4_4", 4'b0000);

    // Shift right
    drive(1, 2'b01, 0, 0, 4'b0110);
    step("load_0110_c", 4'b0110);
    drive(1, 2'b11, 0, 1, 4'b0000);
    step("shr_in1", 4'b1011);
    drive(1, 2'b11, 0, 0, 4'b0000);
    step("shr_in0", 4'b0101);

    // Four serial bits fill the register: oldest inLS lands in bit 3
    bits = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'b10, bits[3-k], 0, 4'b0000);
      @(posedge clk);
    end
    #2 check("shl_serial", out, bits);
    // Shift right: oldest inRS lands in bit 0
    bits = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'b11, 0, bits[k], 4'b0000);
      @(posedge clk);
    end
    #2 check("shr_serial", out, bits);
    want = bits;

    // Exhaustive sweep over clr, set, cntrl, inLS, inRS and in
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] v;
      v = 10'(i);
      @(negedge clk);
      clr   = v[9];
      set   = v[8];
      cntrl = v[7:6];
      inLS  = v[5];
      inRS  = v[4];
      d_in  = v[3:0];
    end

    // Random traffic; clear is kept rare so shift history builds up
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      clr   = ($urandom_range(0, 15) == 0);
      set   = ($urandom_range(0, 7) != 0);
      cntrl = 2'($urandom_range(0, 3));
      inLS  = 1'($urandom);
      inRS  = 1'($urandom);
      d_in  = 4'($urandom);
    end

    @(negedge clk);
    clr = 1'b0; set = 1'b1; cntrl = 2'b00;
    repeat (2) @(posedge clk);
    #3;
    if (want == 4'bxxxx) $display("note: unexpected state");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ld_st_shift_reg.md
# ld_st_shift_reg

4-bit universal register: hold, parallel load, shift left or shift right, with a clear and a preset. It is a general datapath building block used wherever a small loadable/shiftable register is needed, such as operand staging or serial/parallel conversion. All state changes happen on the rising clock edge, except clear, which acts immediately.

## Interface
Parameters: none. Width is fixed at 4 bits.

Ports:
- clk  input  1  system clock; state updates on the rising edge.
- clr  input  1  reset. One clock; reset is asynchronous and active-high. clr=1 forces out to 4'b0000 immediately.
- set  input  1  synchronous preset, active-low. set=0 loads 4'b1111 on the next rising edge.
- cntrl  input  2  mode select: 00 hold, 01 load, 10 shift left, 11 shift right.
- inLS  input  1  serial input that enters bit 0 during a shift left.
- inRS  input  1  serial input that enters bit 3 during a shift right.
- in  input  4  parallel load data.
- out  output  4  register contents, driven directly from flops.

## Operation
Priority runs from highest to lowest:
- clr=1: out = 0000, asynchronously. It holds at 0000 while clr stays high, and it overrides set, cntrl and clk.
- Otherwise, set=0: at posedge, out <= 1111, regardless of cntrl.
- Otherwise, at posedge, cntrl selects:
  - 00: out <= out (hold).
  - 01: out <= in.
  - 10: out <= {out[2:0], inLS}. Bit 3 is discarded.
  - 11: out <= {inRS, out[3:1]}. Bit 0 is discarded.
- No arithmetic is performed; shifts are logical, with no wrap-around and no sign extension.
- There is no output enable. out always reflects the register.

## Timing
- Reset value of out: 4'b0000.
- Clear: asynchronous. out reaches 0000 within combinational delay of clr rising, with no clock needed.
- Clear release: on the first posedge after clr falls, normal operation (set or cntrl) takes effect.
- Preset, load and shift: latency is 1 cycle. The new value is visible after the rising edge on which set, cntrl, in, inLS and inRS are sampled.
- Inputs must be stable around the rising edge (setup/hold). A change between edges has no effect, except for clr.
- Simultaneous events:
  - clr=1 with set=0: result is 0000.
  - set=0 with any cntrl: result is 1111.
  - clr falling at the same time as a rising clock edge is a setup/recovery violation; the bench must avoid it.
- Repeated shifts: after 4 consecutive shift-left cycles, out equals the last four inLS values, with the oldest in bit 3. Shift right behaves symmetrically, with the oldest inRS value in bit 0.

## Test plan
- Async clear: with out=1010, raise clr between clock edges -> out=0000 before the next posedge. Hold clr=1 with set=0 and cntrl=01, in=1111 for 3 clocks -> out stays 0000.
- Preset: clr=0, set=0, cntrl=11, inRS=0 -> out=1111 after 1 posedge. Set priority beats load and shift.
- Load/hold: clr=0, set=1, cntrl=01, in=0110 -> out=0110. Then cntrl=00 for 5 clocks with in changing -> out stays 0110.
- Shift left: out=0110, cntrl=10, inLS=1 -> 1101. Next, inLS=0 -> 1010. After 4 shifts with inLS=0 from 1111 -> 0000.
- Shift right: out=0110, cntrl=11, inRS=1 -> 1011. Next, inRS=0 -> 0101.
- Exhaustive sweep: for every combination of clr, set, cntrl, inLS, inRS and in, apply the stimulus, then compare out against a reference model at 1 ns after each posedge. Run at least 2048 cycles with zero mismatches.
